pll_reset_sequencer: RTL and testbench
======================================

# pll_reset_sequencer

Sequences the reset and lock handshake of the core PLL and produces the single clean reset that releases the core clock domains. It holds the PLL in reset at power-up and synchronises the asynchronous `locked` output. It requires lock to be stable before releasing the core, retries on lock timeout, and re-runs the sequence on loss of lock. It sits in the always-on 74.25 MHz reference domain, between the PLL instance and every core reset tree.

## Interface
- `RST_HOLD_CYCLES`, 16: cycles `pll_rst` is held high per attempt (≥1).
- `LOCK_TIMEOUT`, 74250: cycles allowed in WAIT_LOCK before a retry (1 ms).
- `LOCK_STABLE_CYCLES`, 256: consecutive synchronised-lock cycles required before core release (≥1).
- `MAX_RETRIES`, 3: timeouts tolerated before FAIL (≥1, ≤15).
- `clk_74a` in 1: reference clock, same source as the PLL refclk.
- `reset_n` in 1: asynchronous active-low reset.
- `pll_locked` in 1: PLL `locked`, asynchronous to `clk_74a`.
- `restart` in 1: single-cycle request to re-run the full sequence.
- `pll_rst` out 1: PLL reset, active high.
- `core_reset_n` out 1: core reset, active low. Synchronous deassert to `clk_74a`.
- `lock_fail` out 1: sticky; retries exhausted.
- `retry_count` out 4: timeouts in the current sequence.
- `lock_lost_count` out 8: saturating count of lock losses while in RUN.
- `state` out 3: 0 RESET_PLL, 1 WAIT_LOCK, 2 STABILIZE, 3 RUN, 4 FAIL.

## Operation
- `pll_locked` passes through a 2-FF synchroniser to produce `locked_s`. All decisions use `locked_s`.
- One shared cycle counter, sized for the largest parameter. It is cleared on every state entry.
- RESET_PLL:
  - `pll_rst`=1, `core_reset_n`=0.
  - Stays exactly RST_HOLD_CYCLES cycles, counting the entry cycle, then goes to WAIT_LOCK.
- WAIT_LOCK:
  - `pll_rst`=0.
  - If `locked_s`=1, go to STABILIZE.
  - Otherwise, after LOCK_TIMEOUT cycles in this state, increment `retry_count`. If the new value equals MAX_RETRIES, go to FAIL; else go to RESET_PLL.
  - Lock detection takes priority over timeout in the same cycle.
- STABILIZE:
  - The counter increments each cycle `locked_s`=1.
  - If `locked_s`=0, return to WAIT_LOCK. The timeout restarts from zero and `retry_count` is unchanged.
  - On the LOCK_STABLE_CYCLES-th consecutive locked cycle, go to RUN and clear `retry_count`.
- RUN:
  - `core_reset_n`=1.
  - If `locked_s`=0, increment `lock_lost_count` (saturating at 255) and go to RESET_PLL.
- FAIL:
  - `pll_rst`=1, `core_reset_n`=0, `lock_fail`=1.
  - Only `restart` or `reset_n` leaves this state.
- `restart`:
  - Highest priority; accepted in any state, including RESET_PLL, where the hold count restarts.
  - Goes to RESET_PLL and clears `retry_count` and `lock_fail`.
  - `lock_lost_count` is cleared only by `reset_n`.
- Reset mid-operation: `reset_n` low asynchronously forces all outputs to their reset values, regardless of state.

## Timing
- Reset values:
  - `state`=RESET_PLL, `pll_rst`=1, `core_reset_n`=0.
  - `lock_fail`=0, `retry_count`=0, `lock_lost_count`=0.
  - Synchroniser flops are 0.
- All outputs are registered and decoded from the next state. Each output changes on the same edge as the state it belongs to.
- Synchroniser latency is 2 edges.
  - A `pll_locked` rise is seen by WAIT_LOCK at edge +2 and enters STABILIZE at edge +3.
  - `core_reset_n` rises LOCK_STABLE_CYCLES edges after STABILIZE entry.
- Loss of lock in RUN: `core_reset_n` falls and `pll_rst` rises 3 edges after `pll_locked` falls.
- A `restart` sampled high at edge N gives `pll_rst`=1 and `core_reset_n`=0 from edge N.
- `pll_locked` glitches shorter than one clock may be missed. This is acceptable.

## Test plan
Bench parameters: RST_HOLD_CYCLES=4, LOCK_TIMEOUT=20, STABLE=8, MAX_RETRIES=2.

1. Normal bring-up:
   - Stimulus: release `reset_n`; raise `pll_locked` 5 cycles after `pll_rst` falls and hold it.
   - Required: `pll_rst` high for exactly 4 cycles; `core_reset_n` rises exactly 11 cycles after `pll_locked` rises; `state`=3.
2. Lock flicker:
   - Stimulus: drop `pll_locked` for 3 cycles during STABILIZE.
   - Required: return to WAIT_LOCK; stable count restarts; `core_reset_n` stays 0 until 8 clean cycles; `retry_count`=0.
3. Timeout and retry:
   - Stimulus: `pll_locked` never rises.
   - Required: WAIT_LOCK lasts 20 cycles; `retry_count` 0→1; second `pll_rst` pulse of 4 cycles; after the second timeout, `state`=4, `lock_fail`=1, `pll_rst`=1.
4. Restart from FAIL:
   - Stimulus: pulse `restart` while in FAIL, then lock.
   - Required: `lock_fail`=0 and `retry_count`=0 on that edge; full sequence completes; `core_reset_n`=1.
5. Loss of lock in RUN:
   - Stimulus: drop `pll_locked` 300 times while in RUN.
   - Required: each drop causes `core_reset_n`=0 within 3 cycles and a re-sequence; `lock_lost_count` saturates at 255.
6. Asynchronous reset mid-STABILIZE:
   - Stimulus: pulse `reset_n` low between clock edges.
   - Required: outputs take their reset values immediately, without waiting for a clock edge; `lock_lost_count`=0.

Source files
------------

// File: rtl/pll_reset_sequencer.sv
// PLL reset / lock handshake sequencer for the always-on reference domain.
// Holds the PLL in reset, qualifies a synchronised lock, retries on timeout and releases the core reset.
module pll_reset_sequencer #(
    parameter int RST_HOLD_CYCLES    = 16,
    parameter int LOCK_TIMEOUT       = 74250,
    parameter int LOCK_STABLE_CYCLES = 256,
    parameter int MAX_RETRIES        = 3
) (
    input  logic       clk_74a,
    input  logic       reset_n,
    input  logic       pll_locked,
    input  logic       restart,
    output logic       pll_rst,
    output logic       core_reset_n,
    output logic       lock_fail,
    output logic [3:0] retry_count,
    output logic [7:0] lock_lost_count,
    output logic [2:0] state
);

    localparam int CNT_MAX_A = (RST_HOLD_CYCLES > LOCK_TIMEOUT) ? RST_HOLD_CYCLES : LOCK_TIMEOUT;
    localparam int CNT_MAX   = (CNT_MAX_A > LOCK_STABLE_CYCLES) ? CNT_MAX_A : LOCK_STABLE_CYCLES;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(RST_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO     = '0;
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [3:0]       RETRY_LIMIT  = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        ST_RESET_PLL = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABILIZE = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       retry_q, retry_d;
    logic [7:0]       lost_q, lost_d;
    logic             fail_q, fail_d;
    logic             pll_rst_q;
    logic             core_rst_n_q;
    logic [1:0]       sync_q;
    logic             locked_s;

    // Two-flop synchroniser for the asynchronous PLL lock output.
    always_ff @(posedge clk_74a or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], pll_locked};
        end
    end

    assign locked_s = sync_q[1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_ONE;
        retry_d = retry_q;
        lost_d  = lost_q;
        fail_d  = fail_q;

        if (restart) begin
            state_d = ST_RESET_PLL;
            cnt_d   = CNT_ZERO;
            retry_d = 4'd0;
            fail_d  = 1'b0;
        end else begin
            case (state_q)
                ST_RESET_PLL: begin
                    if (cnt_q == HOLD_LAST) begin
                        state_d = ST_WAIT_LOCK;
                        cnt_d   = CNT_ZERO;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (locked_s) begin
                        state_d = ST_STABILIZE;
                        cnt_d   = CNT_ZERO;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        retry_d = retry_q + 4'd1;
                        cnt_d   = CNT_ZERO;
                        if (retry_d == RETRY_LIMIT) begin
                            state_d = ST_FAIL;
                            fail_d  = 1'b1;
                        end else begin
                            state_d = ST_RESET_PLL;
                        end
                    end
                end
                ST_STABILIZE: begin
                    // Any unlocked cycle sends us back with a fresh timeout window.
                    if (!locked_s) begin
                        state_d = ST_WAIT_LOCK;
                        cnt_d   = CNT_ZERO;
                    end else if (cnt_q == STABLE_LAST) begin
                        state_d = ST_RUN;
                        cnt_d   = CNT_ZERO;
                        retry_d = 4'd0;
                    end
                end
                ST_RUN: begin
                    cnt_d = cnt_q;
                    if (!locked_s) begin
                        state_d = ST_RESET_PLL;
                        cnt_d   = CNT_ZERO;
                        if (lost_q != 8'hFF) begin
                            lost_d = lost_q + 8'd1;
                        end
                    end
                end
                ST_FAIL: begin
                    cnt_d = cnt_q;
                end
                default: begin
                    state_d = ST_RESET_PLL;
                    cnt_d   = CNT_ZERO;
                end
            endcase
        end
    end

    // Outputs decode the next state so they move on the same edge as the state.
    always_ff @(posedge clk_74a or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_RESET_PLL;
            cnt_q        <= CNT_ZERO;
            retry_q      <= 4'd0;
            lost_q       <= 8'd0;
            fail_q       <= 1'b0;
            pll_rst_q    <= 1'b1;
            core_rst_n_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            retry_q      <= retry_d;
            lost_q       <= lost_d;
            fail_q       <= fail_d;
            pll_rst_q    <= (state_d == ST_RESET_PLL) || (state_d == ST_FAIL);
            core_rst_n_q <= (state_d == ST_RUN);
        end
    end

    assign pll_rst         = pll_rst_q;
    assign core_reset_n    = core_rst_n_q;
    assign lock_fail       = fail_q;
    assign retry_count     = retry_q;
    assign lock_lost_count = lost_q;
    assign state           = state_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with small parameters and hand-computed cycle counts.
module tb_pll_reset_sequencer;

    localparam int HOLD = 4;
    localparam int TMO  = 20;
    localparam int STAB = 8;
    localparam int MAXR = 2;

    logic       clk_74a = 1'b0;
    logic       reset_n;
    logic       pll_locked;
    logic       restart;
    logic       pll_rst;
    logic       core_reset_n;
    logic       lock_fail;
    logic [3:0] retry_count;
    logic [7:0] lock_lost_count;
    logic [2:0] state;

    int checks   = 0;
    int failures = 0;

    always #5 clk_74a = ~clk_74a;

    pll_reset_sequencer #(
        .RST_HOLD_CYCLES    (HOLD),
        .LOCK_TIMEOUT       (TMO),
        .LOCK_STABLE_CYCLES (STAB),
        .MAX_RETRIES        (MAXR)
    ) dut (
        .clk_74a         (clk_74a),
        .reset_n         (reset_n),
        .pll_locked      (pll_locked),
        .restart         (restart),
        .pll_rst         (pll_rst),
        .core_reset_n    (core_reset_n),
        .lock_fail       (lock_fail),
        .retry_count     (retry_count),
        .lock_lost_count (lock_lost_count),
        .state           (state)
    );

    task automatic step;
        @(posedge clk_74a);
        #1;
    endtask

    task automatic test_reset;
        reset_n    = 1'b0;
        pll_locked = 1'b0;
        restart    = 1'b0;
        repeat (3) step();
        checks++; if (state !== 3'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state); end
        checks++; if (pll_rst !== 1'b1) begin failures++; $display("FAIL reset_pll_rst got=%b exp=1", pll_rst); end
        checks++; if (core_reset_n !== 1'b0) begin failures++; $display("FAIL reset_core got=%b exp=0", core_reset_n); end
        checks++; if (lock_fail !== 1'b0) begin failures++; $display("FAIL reset_lock_fail got=%b exp=0", lock_fail); end
        checks++; if (retry_count !== 4'd0) begin failures++; $display("FAIL reset_retry got=%0d exp=0", retry_count); end
        checks++; if (lock_lost_count !== 8'd0) begin failures++; $display("FAIL reset_lost got=%0d exp=0", lock_lost_count); end
        #2 reset_n = 1'b1;
        $display("test_reset done");
    endtask

    task automatic test_bringup;
        int n;
        n = 0;
        while (pll_rst === 1'b1 && n < 50) begin step(); n++; end
        checks++; if (n != HOLD) begin failures++; $display("FAIL bringup_pll_rst_len got=%0d exp=%0d", n, HOLD); end
        checks++; if (state !== 3'd1) begin failures++; $display("FAIL bringup_wait_state got=%0d exp=1", state); end
        repeat (5) step();
        pll_locked = 1'b1;
        n = 0;
        while (core_reset_n !== 1'b1 && n < 100) begin
            step();
            n++;
            if (n == 3) begin
                checks++; if (state !== 3'd2) begin failures++; $display("FAIL bringup_stab_entry got=%0d exp=2", state); end
            end
        end
        checks++; if (n != 11) begin failures++; $display("FAIL bringup_core_latency got=%0d exp=11", n); end
        checks++; if (state !== 3'd3) begin failures++; $display("FAIL bringup_run_state got=%0d exp=3", state); end
        checks++; if (pll_rst !== 1'b0) begin failures++; $display("FAIL bringup_pll_rst_run got=%b exp=0", pll_rst); end
        $display("test_bringup done latency=%0d", n);
    endtask

    task automatic test_flicker;
        int n;
        restart = 1'b1;
        step();
        restart = 1'b0;
        checks++; if (state !== 3'd0) begin failures++; $display("FAIL flicker_restart_state got=%0d exp=0", state); end
        checks++; if (core_reset_n !== 1'b0) begin failures++; $display("FAIL flicker_restart_core got=%b exp=0", core_reset_n); end
        n = 0;
        while (state !== 3'd2 && n < 50) begin step(); n++; end
        checks++; if (n != HOLD + 1) begin failures++; $display("FAIL flicker_to_stab got=%0d exp=%0d", n, HOLD + 1); end
        repeat (3) step();
        pll_locked = 1'b0;
        repeat (3) step();
        pll_locked = 1'b1;
        checks++; if (state !== 3'd1) begin failures++; $display("FAIL flicker_back_wait got=%0d exp=1", state); end
        checks++; if (retry_count !== 4'd0) begin failures++; $display("FAIL flicker_retry got=%0d exp=0", retry_count); end
        checks++; if (core_reset_n !== 1'b0) begin failures++; $display("FAIL flicker_core_low got=%b exp=0", core_reset_n); end
        n = 0;
        while (state !== 3'd2 && n < 50) begin step(); n++; end
        checks++; if (n != 3) begin failures++; $display("FAIL flicker_restab got=%0d exp=3", n); end
        n = 0;
        while (core_reset_n !== 1'b1 && n < 50) begin step(); n++; end
        checks++; if (n != STAB) begin failures++; $display("FAIL flicker_stable_len got=%0d exp=%0d", n, STAB); end
        checks++; if (state !== 3'd3) begin failures++; $display("FAIL flicker_run got=%0d exp=3", state); end
        $display("test_flicker done");
    endtask

    task automatic test_timeout;
        int n;
        pll_locked = 1'b0;
        restart    = 1'b1;
        step();
        restart = 1'b0;
        checks++; if (state !== 3'd0) begin failures++; $display("FAIL timeout_restart_state got=%0d exp=0", state); end
        n = 0;
        while (state === 3'd0 && n < 50) begin step(); n++; end
        checks++; if (n != HOLD) begin failures++; $display("FAIL timeout_hold1 got=%0d exp=%0d", n, HOLD); end
        n = 0;
        while (state === 3'd1 && n < 100) begin step(); n++; end
        checks++; if (n != TMO) begin failures++; $display("FAIL timeout_wait1 got=%0d exp=%0d", n, TMO); end
        checks++; if (state !== 3'd0) begin failures++; $display("FAIL timeout_retry_state got=%0d exp=0", state); end
        checks++; if (retry_count !== 4'd1) begin failures++; $display("FAIL timeout_retry1 got=%0d exp=1", retry_count); end
        n = 0;
        while (state === 3'd0 && n < 50) begin step(); n++; end
        checks++; if (n != HOLD) begin failures++; $display("FAIL timeout_hold2 got=%0d exp=%0d", n, HOLD); end
        n = 0;
        while (state === 3'd1 && n < 100) begin step(); n++; end
        checks++; if (n != TMO) begin failures++; $display("FAIL timeout_wait2 got=%0d exp=%0d", n, TMO); end
        checks++; if (state !== 3'd4) begin failures++; $display("FAIL timeout_fail_state got=%0d exp=4", state); end
        checks++; if (lock_fail !== 1'b1) begin failures++; $display("FAIL timeout_lock_fail got=%b exp=1", lock_fail); end
        checks++; if (pll_rst !== 1'b1) begin failures++; $display("FAIL timeout_pll_rst got=%b exp=1", pll_rst); end
        checks++; if (retry_count !== 4'(MAXR)) begin failures++; $display("FAIL timeout_retry2 got=%0d exp=%0d", retry_count, MAXR); end
        repeat (5) step();
        checks++; if (state !== 3'd4) begin failures++; $display("FAIL timeout_fail_sticky got=%0d exp=4", state); end
        checks++; if (core_reset_n !== 1'b0) begin failures++; $display("FAIL timeout_core got=%b exp=0", core_reset_n); end
        $display("test_timeout done");
    endtask

    task automatic test_restart_fail;
        int n;
        pll_locked = 1'b1;
        restart    = 1'b1;
        step();
        restart = 1'b0;
        checks++; if (state !== 3'd0) begin failures++; $display("FAIL rfail_state got=%0d exp=0", state); end
        checks++; if (lock_fail !== 1'b0) begin failures++; $display("FAIL rfail_lock_fail got=%b exp=0", lock_fail); end
        checks++; if (retry_count !== 4'd0) begin failures++; $display("FAIL rfail_retry got=%0d exp=0", retry_count); end
        checks++; if (pll_rst !== 1'b1) begin failures++; $display("FAIL rfail_pll_rst got=%b exp=1", pll_rst); end
        n = 0;
        while (core_reset_n !== 1'b1 && n < 100) begin step(); n++; end
        checks++; if (n != 13) begin failures++; $display("FAIL rfail_seq_len got=%0d exp=13", n); end
        checks++; if (state !== 3'd3) begin failures++; $display("FAIL rfail_run got=%0d exp=3", state); end
        $display("test_restart_fail done");
    endtask

    task automatic test_lock_loss;
        int n;
        int exp_lost;
        for (int i = 1; i <= 300; i++) begin
            exp_lost   = (i > 255) ? 255 : i;
            pll_locked = 1'b0;
            step();
            step();
            checks++; if (core_reset_n !== 1'b1) begin failures++; $display("FAIL loss_core_early[%0d] got=%b exp=1", i, core_reset_n); end
            step();
            checks++; if (core_reset_n !== 1'b0) begin failures++; $display("FAIL loss_core_fall[%0d] got=%b exp=0", i, core_reset_n); end
            checks++; if (pll_rst !== 1'b1) begin failures++; $display("FAIL loss_pll_rst[%0d] got=%b exp=1", i, pll_rst); end
            checks++; if (lock_lost_count !== 8'(exp_lost)) begin failures++; $display("FAIL loss_count[%0d] got=%0d exp=%0d", i, lock_lost_count, exp_lost); end
            pll_locked = 1'b1;
            n = 0;
            while (core_reset_n !== 1'b1 && n < 100) begin step(); n++; end
            checks++; if (n != 13) begin failures++; $display("FAIL loss_reseq[%0d] got=%0d exp=13", i, n); end
        end
        $display("test_lock_loss done lost=%0d", lock_lost_count);
    endtask

    task automatic test_async_reset;
        int n;
        restart = 1'b1;
        step();
        restart = 1'b0;
        n = 0;
        while (state !== 3'd2 && n < 50) begin step(); n++; end
        checks++; if (state !== 3'd2) begin failures++; $display("FAIL areset_in_stab got=%0d exp=2", state); end
        step();
        step();
        #3 reset_n = 1'b0;
        #1;
        checks++; if (state !== 3'd0) begin failures++; $display("FAIL areset_state got=%0d exp=0", state); end
        checks++; if (pll_rst !== 1'b1) begin failures++; $display("FAIL areset_pll_rst got=%b exp=1", pll_rst); end
        checks++; if (core_reset_n !== 1'b0) begin failures++; $display("FAIL areset_core got=%b exp=0", core_reset_n); end
        checks++; if (lock_lost_count !== 8'd0) begin failures++; $display("FAIL areset_lost got=%0d exp=0", lock_lost_count); end
        checks++; if (retry_count !== 4'd0) begin failures++; $display("FAIL areset_retry got=%0d exp=0", retry_count); end
        step();
        #3 reset_n = 1'b1;
        n = 0;
        while (pll_rst === 1'b1 && n < 50) begin step(); n++; end
        checks++; if (n != HOLD) begin failures++; $display("FAIL areset_hold got=%0d exp=%0d", n, HOLD); end
        $display("test_async_reset done");
    endtask

    initial begin
        test_reset();
        test_bringup();
        test_flicker();
        test_timeout();
        test_restart_fail();
        test_lock_loss();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
